// File: rtl/hazard_scoreboard_ctrl.sv
// Stall/flush controller for the 5-stage rv32i pipeline: per-register countdown scoreboard,
// memory-wait FSM with hang watchdog and saturating performance counters.
module hazard_scoreboard_ctrl #(
    parameter int unsigned NUM_REGS      = 32,
    parameter int unsigned REG_IDX_W     = 5,
    parameter int unsigned LAT_ALU       = 1,
    parameter int unsigned LAT_LOAD      = 2,
    parameter int unsigned EARLY_RESOLVE = 1,
    parameter int unsigned TIMEOUT       = 1024,
    parameter int unsigned PERF_W        = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 instr_mem_resp,
    input  logic                 data_mem_resp,
    input  logic                 dmem_req,
    input  logic                 id_valid,
    input  logic [REG_IDX_W-1:0] id_rs1,
    input  logic [REG_IDX_W-1:0] id_rs2,
    input  logic                 id_rs1_used,
    input  logic                 id_rs2_used,
    input  logic                 id_early,
    input  logic [REG_IDX_W-1:0] id_rd,
    input  logic                 id_rd_we,
    input  logic [1:0]           id_lat_class,
    input  logic                 mc_done,
    input  logic [REG_IDX_W-1:0] mc_rd,
    input  logic                 redirect,
    output logic                 load_pc,
    output logic                 if_id_load,
    output logic                 id_ex_load,
    output logic                 ex_mem_load,
    output logic                 mem_wb_load,
    output logic                 if_id_flush,
    output logic                 id_ex_flush,
    output logic                 global_stall,
    output logic                 hazard_stall,
    output logic                 hang_err,
    output logic [PERF_W-1:0]    perf_mem_stall,
    output logic [PERF_W-1:0]    perf_haz_stall,
    output logic [PERF_W-1:0]    perf_redirect
);

    localparam int unsigned CNT_W  = 3;
    localparam int unsigned WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0]  LAT_ALU_C  = CNT_W'(LAT_ALU);
    localparam logic [CNT_W-1:0]  LAT_LOAD_C = CNT_W'(LAT_LOAD);
    localparam logic [WAIT_W-1:0] WAIT_MAX   = WAIT_W'(TIMEOUT - 1);
    localparam logic [PERF_W-1:0] PERF_MAX   = '1;

    typedef enum logic {S_RUN = 1'b0, S_WAIT = 1'b1} state_t;

    state_t              state_q, state_d;
    logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
    logic                hang_d;
    logic [CNT_W-1:0]    cnt_q [NUM_REGS];
    logic [CNT_W-1:0]    cnt_d [NUM_REGS];
    logic [NUM_REGS-1:0] busy_q, busy_d;
    logic                mc_active_q, mc_active_d;

    logic             mem_stall_c;
    logic [CNT_W-1:0] need_c;
    logic             rs1_haz_c, rs2_haz_c, struct_haz_c, hazard_c;
    logic             issue_c, redirect_take_c;
    logic [WAIT_W-1:0] wait_base_c;

    // Hazard detection against the current scoreboard contents
    always_comb begin
        mem_stall_c  = ~instr_mem_resp | (dmem_req & ~data_mem_resp);
        need_c       = (id_early && (EARLY_RESOLVE != 0)) ? CNT_W'(0) : CNT_W'(1);
        rs1_haz_c    = id_rs1_used && (id_rs1 != '0) &&
                       (busy_q[id_rs1] || (cnt_q[id_rs1] > need_c));
        rs2_haz_c    = id_rs2_used && (id_rs2 != '0) &&
                       (busy_q[id_rs2] || (cnt_q[id_rs2] > need_c));
        struct_haz_c = (id_lat_class == 2'd2) && mc_active_q;
        hazard_c     = id_valid && (rs1_haz_c || rs2_haz_c || struct_haz_c);
        issue_c      = ~mem_stall_c && ~hazard_c && id_valid && id_rd_we && (id_rd != '0);
        redirect_take_c = ~mem_stall_c && ~hazard_c && redirect;
    end

    // Pipeline control outputs and memory-wait FSM next state
    always_comb begin
        load_pc      = 1'b0;
        if_id_load   = 1'b0;
        id_ex_load   = 1'b0;
        ex_mem_load  = 1'b0;
        mem_wb_load  = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b0;
        global_stall = 1'b0;
        hazard_stall = 1'b0;
        state_d      = state_q;
        wait_cnt_d   = '0;
        hang_d       = hang_err;
        wait_base_c  = (state_q == S_WAIT) ? wait_cnt_q : '0;

        if (!rst) begin
            load_pc = 1'b0;
        end else if (mem_stall_c) begin
            global_stall = 1'b1;
        end else if (hazard_c) begin
            id_ex_load   = 1'b1;
            ex_mem_load  = 1'b1;
            mem_wb_load  = 1'b1;
            id_ex_flush  = 1'b1;
            hazard_stall = 1'b1;
        end else begin
            load_pc     = 1'b1;
            if_id_load  = 1'b1;
            id_ex_load  = 1'b1;
            ex_mem_load = 1'b1;
            mem_wb_load = 1'b1;
            if_id_flush = redirect;
        end

        unique case (state_q)
            S_RUN:   if (mem_stall_c)  state_d = S_WAIT;
            S_WAIT:  if (!mem_stall_c) state_d = S_RUN;
            default: state_d = S_RUN;
        endcase

        if (mem_stall_c) begin
            wait_cnt_d = (wait_base_c == WAIT_MAX) ? WAIT_MAX : wait_base_c + WAIT_W'(1);
            if (wait_base_c == WAIT_MAX) hang_d = 1'b1;
        end
    end

    // Scoreboard next state: decrement, then multicycle completion, then issue (issue wins)
    always_comb begin
        cnt_d       = cnt_q;
        busy_d      = busy_q;
        mc_active_d = mc_active_q;
        if (!mem_stall_c) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                if (cnt_q[r] != '0) cnt_d[r] = cnt_q[r] - CNT_W'(1);
            end
        end
        if (mc_done && (mc_rd != '0)) begin
            busy_d[mc_rd] = 1'b0;
            cnt_d[mc_rd]  = LAT_ALU_C;
            mc_active_d   = 1'b0;
        end
        if (issue_c) begin
            unique case (id_lat_class)
                2'd1: cnt_d[id_rd] = LAT_LOAD_C;
                2'd2: begin
                    busy_d[id_rd] = 1'b1;
                    cnt_d[id_rd]  = '0;
                    mc_active_d   = 1'b1;
                end
                default: cnt_d[id_rd] = LAT_ALU_C;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_RUN;
            wait_cnt_q  <= '0;
            hang_err    <= 1'b0;
            busy_q      <= '0;
            mc_active_q <= 1'b0;
            for (int r = 0; r < NUM_REGS; r++) cnt_q[r] <= '0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            hang_err    <= hang_d;
            busy_q      <= busy_d;
            mc_active_q <= mc_active_d;
            for (int r = 0; r < NUM_REGS; r++) cnt_q[r] <= cnt_d[r];
        end
    end

    // Saturating performance counters
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_mem_stall <= '0;
            perf_haz_stall <= '0;
            perf_redirect  <= '0;
        end else begin
            if (mem_stall_c && (perf_mem_stall != PERF_MAX))
                perf_mem_stall <= perf_mem_stall + PERF_W'(1);
            if (!mem_stall_c && hazard_c && (perf_haz_stall != PERF_MAX))
                perf_haz_stall <= perf_haz_stall + PERF_W'(1);
            if (redirect_take_c && (perf_redirect != PERF_MAX))
                perf_redirect <= perf_redirect + PERF_W'(1);
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard_ctrl.sv
// Randomized and directed bench for hazard_scoreboard_ctrl against a cycle-level reference model.
module tb_hazard_scoreboard_ctrl;

    localparam int LAT_ALU  = 1;
    localparam int LAT_LOAD = 2;
    localparam int EARLY    = 1;
    localparam int TIMEOUT  = 8;
    localparam int PERF_W   = 8;
    localparam int PMAX     = (1 << PERF_W) - 1;

    logic clk, rst;
    logic instr_mem_resp, data_mem_resp, dmem_req, id_valid;
    logic [4:0] id_rs1, id_rs2, id_rd, mc_rd;
    logic id_rs1_used, id_rs2_used, id_early, id_rd_we, mc_done, redirect;
    logic [1:0] id_lat_class;
    logic load_pc, if_id_load, id_ex_load, ex_mem_load, mem_wb_load;
    logic if_id_flush, id_ex_flush, global_stall, hazard_stall, hang_err;
    logic [PERF_W-1:0] perf_mem_stall, perf_haz_stall, perf_redirect;

    hazard_scoreboard_ctrl #(
        .NUM_REGS(32), .REG_IDX_W(5), .LAT_ALU(LAT_ALU), .LAT_LOAD(LAT_LOAD),
        .EARLY_RESOLVE(EARLY), .TIMEOUT(TIMEOUT), .PERF_W(PERF_W)
    ) dut (
        .clk(clk), .rst(rst),
        .instr_mem_resp(instr_mem_resp), .data_mem_resp(data_mem_resp), .dmem_req(dmem_req),
        .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .id_early(id_early),
        .id_rd(id_rd), .id_rd_we(id_rd_we), .id_lat_class(id_lat_class),
        .mc_done(mc_done), .mc_rd(mc_rd), .redirect(redirect),
        .load_pc(load_pc), .if_id_load(if_id_load), .id_ex_load(id_ex_load),
        .ex_mem_load(ex_mem_load), .mem_wb_load(mem_wb_load),
        .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
        .global_stall(global_stall), .hazard_stall(hazard_stall), .hang_err(hang_err),
        .perf_mem_stall(perf_mem_stall), .perf_haz_stall(perf_haz_stall),
        .perf_redirect(perf_redirect)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state
    int m_cnt [32];
    bit m_busy [32];
    bit m_mc, m_hang;
    int m_run, m_pm, m_ph, m_pr;

    int n_vec, n_err;
    bit obs_haz, obs_gs, obs_ifflush;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit src_haz(input bit used, input int s, input int need);
        return used && (s != 0) && (m_busy[s] || (m_cnt[s] > need));
    endfunction

    task automatic model_reset();
        for (int r = 0; r < 32; r++) begin
            m_cnt[r]  = 0;
            m_busy[r] = 1'b0;
        end
        m_mc = 0; m_hang = 0; m_run = 0; m_pm = 0; m_ph = 0; m_pr = 0;
    endtask

    task automatic model_update(input bit ms, input bit hz);
        if (!ms)
            for (int r = 0; r < 32; r++) if (m_cnt[r] > 0) m_cnt[r]--;
        if (mc_done && mc_rd != 0) begin
            m_busy[mc_rd] = 1'b0;
            m_cnt[mc_rd]  = LAT_ALU;
            m_mc          = 1'b0;
        end
        if (!ms && !hz && id_valid && id_rd_we && id_rd != 0) begin
            if (id_lat_class == 2'd1) m_cnt[id_rd] = LAT_LOAD;
            else if (id_lat_class == 2'd2) begin
                m_busy[id_rd] = 1'b1;
                m_cnt[id_rd]  = 0;
                m_mc          = 1'b1;
            end else m_cnt[id_rd] = LAT_ALU;
        end
        if (ms) m_pm = (m_pm == PMAX) ? PMAX : m_pm + 1;
        if (!ms && hz) m_ph = (m_ph == PMAX) ? PMAX : m_ph + 1;
        if (!ms && !hz && redirect) m_pr = (m_pr == PMAX) ? PMAX : m_pr + 1;
        if (ms) begin
            if (m_run >= TIMEOUT - 1) m_hang = 1'b1;
            m_run++;
        end else m_run = 0;
    endtask

    // One cycle: inputs were set at the falling edge; check, advance the model, wait for next fall
    task automatic tick();
        logic [8:0] exp_ctrl, obs_ctrl;
        bit ms, hz;
        int need;
        #1;
        if (!rst) model_reset();
        ms   = !instr_mem_resp || (dmem_req && !data_mem_resp);
        need = (id_early && EARLY != 0) ? 0 : 1;
        hz   = id_valid && (src_haz(id_rs1_used, int'(id_rs1), need) ||
                            src_haz(id_rs2_used, int'(id_rs2), need) ||
                            (id_lat_class == 2'd2 && m_mc));
        if (!rst)          exp_ctrl = 9'b0_0000_0000;
        else if (ms)       exp_ctrl = 9'b0_0000_0010;
        else if (hz)       exp_ctrl = 9'b0_0111_0101;
        else if (redirect) exp_ctrl = 9'b1_1111_1000;
        else               exp_ctrl = 9'b1_1111_0000;
        obs_ctrl = {load_pc, if_id_load, id_ex_load, ex_mem_load, mem_wb_load,
                    if_id_flush, id_ex_flush, global_stall, hazard_stall};
        check("ctrl", 32'(obs_ctrl), 32'(exp_ctrl));
        check("hang_err", 32'(hang_err), 32'(m_hang));
        check("perf_mem_stall", 32'(perf_mem_stall), m_pm);
        check("perf_haz_stall", 32'(perf_haz_stall), m_ph);
        check("perf_redirect", 32'(perf_redirect), m_pr);
        obs_haz = hazard_stall; obs_gs = global_stall; obs_ifflush = if_id_flush;
        if (rst) model_update(ms, hz);
        @(negedge clk);
    endtask

    task automatic set_idle();
        instr_mem_resp = 1; data_mem_resp = 1; dmem_req = 0; id_valid = 0;
        id_rs1 = 0; id_rs2 = 0; id_rs1_used = 0; id_rs2_used = 0; id_early = 0;
        id_rd = 0; id_rd_we = 0; id_lat_class = 0; mc_done = 0; mc_rd = 0; redirect = 0;
    endtask

    task automatic produce(input int rd, input int cls);
        set_idle();
        id_valid = 1; id_rd = 5'(rd); id_rd_we = 1; id_lat_class = 2'(cls);
        tick();
    endtask

    // Present one consumer until it issues; count hazard bubbles and memory-stall cycles
    task automatic consume(input int rs, input bit early, input int cls, input int rd,
                           input int mc_at, input int mcrd, input int dmiss,
                           output int bubbles, output int gstalls);
        bit done = 0;
        bubbles = 0; gstalls = 0;
        for (int k = 0; k < 30; k++) begin
            set_idle();
            id_valid = 1; id_rs1 = 5'(rs); id_rs1_used = 1; id_early = early;
            id_lat_class = 2'(cls); id_rd = 5'(rd); id_rd_we = (rd != 0);
            if (k == mc_at) begin mc_done = 1; mc_rd = 5'(mcrd); end
            if (k < dmiss) begin dmem_req = 1; data_mem_resp = 0; end
            tick();
            if (obs_haz) bubbles++;
            else if (obs_gs) gstalls++;
            else begin done = 1; break; end
        end
        if (!done) check("consume_timeout", 0, 1);
    endtask

    task automatic do_reset();
        set_idle();
        rst = 0;
        tick(); tick();
        rst = 1;
        tick();
    endtask

    int b, g;

    initial begin
        n_vec = 0; n_err = 0;
        model_reset();
        rst = 0;
        set_idle();
        tick(); tick();
        rst = 1;

        // Randomized traffic over a small register window to provoke hazards
        for (int i = 0; i < 3000; i++) begin
            instr_mem_resp = ($urandom_range(0, 9) != 0);
            dmem_req       = ($urandom_range(0, 9) < 3);
            data_mem_resp  = ($urandom_range(0, 9) < 7);
            id_valid       = ($urandom_range(0, 19) < 17);
            id_rs1         = 5'($urandom_range(0, 7));
            id_rs2         = 5'($urandom_range(0, 7));
            id_rs1_used    = 1'($urandom_range(0, 1));
            id_rs2_used    = 1'($urandom_range(0, 1));
            id_early       = ($urandom_range(0, 9) < 3);
            id_rd          = 5'($urandom_range(0, 7));
            id_rd_we       = ($urandom_range(0, 9) < 8);
            id_lat_class   = 2'($urandom_range(0, 3));
            mc_done        = ($urandom_range(0, 9) == 0);
            mc_rd          = 5'($urandom_range(0, 7));
            redirect       = ($urandom_range(0, 9) == 0);
            tick();
        end

        do_reset();
        produce(5, 0);  consume(5, 1, 0, 0, -1, 0, 0, b, g);
        check("alu_early_bubbles", 32'(b), 1);
        produce(6, 1);  consume(6, 0, 0, 7, -1, 0, 0, b, g);
        check("load_use_bubbles", 32'(b), 1);
        produce(6, 1);  consume(6, 1, 0, 0, -1, 0, 0, b, g);
        check("load_branch_bubbles", 32'(b), 2);
        produce(0, 1);  consume(0, 1, 0, 0, -1, 0, 0, b, g);
        check("x0_bubbles", 32'(b), 0);
        produce(6, 1);  consume(6, 0, 0, 7, -1, 0, 5, b, g);
        check("dmiss_bubbles", 32'(b), 1);
        check("dmiss_gstalls", 32'(g), 5);
        produce(8, 2);  consume(8, 0, 0, 11, 5, 8, 0, b, g);
        check("mul_dep_bubbles", 32'(b), 6);
        produce(9, 2);  consume(0, 0, 2, 10, 2, 9, 0, b, g);
        check("mul_struct_bubbles", 32'(b), 3);

        set_idle(); id_valid = 1; redirect = 1;
        tick();
        check("redirect_flush", 32'(obs_ifflush), 1);
        produce(5, 0);
        set_idle(); id_valid = 1; id_rs1 = 5; id_rs1_used = 1; id_early = 1; redirect = 1;
        tick();
        check("redirect_in_haz_stall", 32'(obs_haz), 1);
        check("redirect_in_haz_flush", 32'(obs_ifflush), 0);
        set_idle(); tick();

        // Watchdog: eight stalled fetch cycles trip the sticky error
        set_idle(); instr_mem_resp = 0;
        for (int i = 0; i < TIMEOUT - 1; i++) tick();
        check("hang_before_timeout", 32'(hang_err), 0);
        tick();
        check("hang_at_timeout", 32'(hang_err), 1);
        set_idle();
        tick(); tick(); tick();
        check("hang_sticky", 32'(hang_err), 1);
        instr_mem_resp = 0;
        tick(); tick();
        rst = 0;
        tick();
        check("rst_mid_stall_hang", 32'(hang_err), 0);
        check("rst_mid_stall_gstall", 32'(global_stall), 0);
        check("rst_mid_stall_perf", 32'(perf_mem_stall), 0);
        rst = 1; set_idle();
        tick(); tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
